// File: rtl/imem_fetch_port_if.sv
// imem_fetch_port_if: fetch request/response, program-load and status bundle.
// The master side is the fetch stage or bench; the slave side is the memory.
interface imem_fetch_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] instruction;
  logic              fault;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              busy;

  modport master (
    output req_valid, pc, rsp_ready,
    output ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid,
    input  instruction, fault, busy
  );

  modport slave (
    input  req_valid, pc, rsp_ready,
    input  ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid,
    output instruction, fault, busy
  );
endinterface

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: LEGv8 instruction memory, registered fetch port, zero-fill.
// IMEM_ADDR_CHECK_EN: fault bad fetches and drop out-of-range loads.
module imem_fetch_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  imem_fetch_port_if.slave s
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic              run;
  logic              req_ready;
  logic              accept;
  logic              rd_bad;
  logic              ld_bad;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  ld_idx;
  logic              unused_bits;

  assign rd_idx      = s.pc[IDX_W+1:2];
  assign ld_idx      = s.ld_addr[IDX_W+1:2];
  assign unused_bits = ^{s.pc, s.ld_addr};

`ifdef IMEM_ADDR_CHECK_EN
  assign rd_bad  = (s.pc[1:0] != 2'b00) ||
                   ((s.pc >> (IDX_W + 2)) != '0);
  assign ld_bad  = (s.ld_addr >> (IDX_W + 2)) != '0;
  assign s.fault = fault_q;
`else
  logic unused_fault;
  assign rd_bad       = 1'b0;
  assign ld_bad       = 1'b0;
  assign unused_fault = fault_q;
  assign s.fault      = 1'b0;
`endif

  assign run           = (state_q == RUN);
  assign req_ready     = run && (!rsp_valid_q || s.rsp_ready);
  assign accept        = s.req_valid && req_ready;
  assign s.req_ready   = req_ready;
  assign s.busy        = !run;
  assign s.rsp_valid   = rsp_valid_q;
  assign s.instruction = instr_q;

  // Clear sequencer owns the write port until every word is zeroed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_widx  = cnt_q;
    mem_wdata = '0;
    unique case (state_q)
      CLEAR: begin
        mem_we = !reset;
        cnt_d  = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (s.ld_en && !ld_bad && !reset) begin
          mem_we    = 1'b1;
          mem_widx  = ld_idx;
          mem_wdata = s.ld_data;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    instr_d     = instr_q;
    fault_d     = fault_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      instr_d     = rd_bad ? '0 : mem_q[rd_idx];
      fault_d     = rd_bad;
    end else if (s.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      instr_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      instr_q     <= instr_d;
      fault_q     <= fault_d;
    end
  end

  // Read above sees the pre-edge word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end
endmodule
